// File: rtl/adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM encoding and the
// derived digit-count / counter-width helpers used at elaboration time.
package adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Number of digits needed to cover a full operand.
  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // Digit counter width; never zero so NDIG=1 still gets a legal vector.
  function automatic int cnt_width(input int width, input int digit);
    int n;
    n = width / digit;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder; also exposes the carry into its top
// bit so the caller can form signed overflow on the final digit.
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co    = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial two's-complement adder/subtractor: WIDTH-bit operands are
// consumed DIGIT bits per clock, LSB digit first, with a start/busy/done handshake.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("serial_adder: WIDTH=%0d must be a positive multiple of DIGIT=%0d", WIDTH, DIGIT);
  end

  localparam int NDIG = ndig(WIDTH, DIGIT);
  localparam int CW   = cnt_width(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;

  logic [DIGIT-1:0] dsum;
  logic             dco;
  logic             dcm;
  logic [WIDTH-1:0] acc_next;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x    (opa[DIGIT-1:0]),
    .y    (opb[DIGIT-1:0]),
    .ci   (carry),
    .s    (dsum),
    .co   (dco),
    .c_msb(dcm)
  );

  // New digit enters at the MSB end; after NDIG shifts the word is aligned.
  assign acc_next = WIDTH'({dsum, acc} >> DIGIT);

  // NOTE: the operand/partial-sum shift registers carry no reset; their
  // contents are always reloaded at accept and never observed before then.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      opa <= a;
      opb <= b ^ {WIDTH{sub}};
    end else if (state == RUN) begin
      opa <= opa >> DIGIT;
      opb <= opb >> DIGIT;
      acc <= acc_next;
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others, as the hardware does.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      cnt   <= '0;
      carry <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            cnt   <= '0;
            // Subtraction is a + ~b + 1 - borrow, so the initial carry is cin^sub.
            carry <= cin ^ sub;
          end
        end
        RUN: begin
          carry <= dco;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            sum   <= acc_next;
            cout  <= dco;
            ovf   <= dcm ^ dco;
            cnt   <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed vectors, handshake corner
// cases and a randomized sweep of four configurations against an arithmetic model.
module tb_serial_adder;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  start_v;
  logic        sub;
  logic        cin;
  logic [31:0] a;
  logic [31:0] b;

  wire  [3:0]  busy_v;
  wire  [3:0]  done_v;
  wire  [3:0]  cout_v;
  wire  [3:0]  ovf_v;
  logic [31:0] sum0, sum1, sum2;
  logic [7:0]  sum3;

  int checks = 0;
  int errors = 0;

  // Configurations: 0 = 32/4, 1 = 32/1, 2 = 32/32, 3 = 8/2
  int width_c[4] = '{32, 32, 32, 8};
  int ndig_c[4]  = '{8, 32, 1, 4};

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(32), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub), .cin(cin), .a(a), .b(b),
    .busy(busy_v[0]), .done(done_v[0]), .sum(sum0), .cout(cout_v[0]), .ovf(ovf_v[0])
  );

  serial_adder #(.WIDTH(32), .DIGIT(1)) dut_d1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub), .cin(cin), .a(a), .b(b),
    .busy(busy_v[1]), .done(done_v[1]), .sum(sum1), .cout(cout_v[1]), .ovf(ovf_v[1])
  );

  serial_adder #(.WIDTH(32), .DIGIT(32)) dut_d32 (
    .clk(clk), .rst(rst), .start(start_v[2]), .sub(sub), .cin(cin), .a(a), .b(b),
    .busy(busy_v[2]), .done(done_v[2]), .sum(sum2), .cout(cout_v[2]), .ovf(ovf_v[2])
  );

  serial_adder #(.WIDTH(8), .DIGIT(2)) dut_w8 (
    .clk(clk), .rst(rst), .start(start_v[3]), .sub(sub), .cin(cin), .a(a[7:0]), .b(b[7:0]),
    .busy(busy_v[3]), .done(done_v[3]), .sum(sum3), .cout(cout_v[3]), .ovf(ovf_v[3])
  );

  function automatic logic [31:0] get_sum(input int c);
    case (c)
      0:       return sum0;
      1:       return sum1;
      2:       return sum2;
      default: return {24'h0, sum3};
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on a w-bit word; returns {sum, cout, ovf}.
  function automatic logic [33:0] model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                        input logic s, input logic ci);
    longint m    = (longint'(1) << w) - 1;
    longint half = longint'(1) << (w - 1);
    longint ua   = longint'(av) & m;
    longint ub   = longint'(bv) & m;
    longint sa   = (ua >= half) ? ua - 2 * half : ua;
    longint sb   = (ub >= half) ? ub - 2 * half : ub;
    longint ic   = longint'(ci);
    longint u;
    longint r;
    logic   c;
    logic [31:0] res;
    if (!s) begin
      u = ua + ub + ic;
      c = (u > m);
      r = sa + sb + ic;
    end else begin
      u = ua - ub - ic;
      c = (ua >= ub + ic);
      r = sa - sb - ic;
    end
    res = 32'(u & m);
    return {res, c, (r >= half) || (r < -half)};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h8080_8080;
      5:       return 32'h7F7F_7F7F;
      default: return $urandom();
    endcase
  endfunction

  // Cycles from the accept edge until done is seen; capped so a stuck DUT cannot hang.
  task automatic wait_done(input int c, output int lat);
    lat = 0;
    while (!done_v[c] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic accept(input int c, input logic [31:0] av, input logic [31:0] bv,
                        input logic s, input logic ci);
    a = av; b = bv; sub = s; cin = ci;
    start_v[c] = 1'b1;
    @(posedge clk); #1;
    start_v[c] = 1'b0;
  endtask

  task automatic run_op(input int c, input logic [31:0] av, input logic [31:0] bv,
                        input logic s, input logic ci, output int lat);
    accept(c, av, bv, s, ci);
    wait_done(c, lat);
  endtask

  initial begin
    vec_t        vecs[8];
    int          lat;
    int          dones;
    logic [31:0] av, bv;
    logic        s, ci;

    vecs[0] = '{32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1] = '{32'h5,         32'h7,         1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[2] = '{32'h5,         32'h7,         1'b1, 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0};
    vecs[3] = '{32'h7FFF_FFFF, 32'h1,         1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[4] = '{32'h8000_0000, 32'h1,         1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[5] = '{32'h0,         32'h0,         1'b0, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
    vecs[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[7] = '{32'h0,         32'h0,         1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};

    rst = 1'b1; start_v = '0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", busy_v[0], 0);
    check("reset done", done_v[0], 0);
    check("reset sum",  sum0, 0);
    check("reset cout", cout_v[0], 0);
    check("reset ovf",  ovf_v[0], 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors
    foreach (vecs[i]) begin
      run_op(0, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, lat);
      check($sformatf("vec%0d latency", i), lat, 8);
      check($sformatf("vec%0d sum", i),  sum0, vecs[i].sum);
      check($sformatf("vec%0d cout", i), cout_v[0], vecs[i].cout);
      check($sformatf("vec%0d ovf", i),  ovf_v[0], vecs[i].ovf);
    end

    // start pulsed 3 cycles into an operation with other operands is ignored
    accept(0, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    check("ignore busy after accept", busy_v[0], 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; sub = 1'b1; cin = 1'b1;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    wait_done(0, lat);
    check("ignore latency", lat + 3, 8);
    check("ignore sum", sum0, 32'h3333_3333);
    check("ignore cout", cout_v[0], 0);
    @(posedge clk); #1;
    check("ignore no restart busy", busy_v[0], 0);
    check("ignore done drops", done_v[0], 0);

    // start on the done cycle is accepted back-to-back
    run_op(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, lat);
    check("b2b first done", done_v[0], 1);
    check("b2b first sum", sum0, 32'h0000_0100);
    accept(0, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
    check("b2b busy again", busy_v[0], 1);
    check("b2b done cleared", done_v[0], 0);
    check("b2b sum held", sum0, 32'h0000_0100);
    wait_done(0, lat);
    check("b2b second latency", lat, 8);
    check("b2b second sum", sum0, 32'h0123_4567);
    check("b2b second cout", cout_v[0], 1);

    // Reset at digit 4 aborts the operation
    accept(0, 32'h0F0F_0F0F, 32'h1010_1010, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort busy", busy_v[0], 0);
    check("abort done", done_v[0], 0);
    check("abort sum", sum0, 0);
    dones = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done_v[0]) dones++;
    end
    check("abort no done pulse", dones, 0);
    run_op(0, 32'h0F0F_0F0F, 32'h1010_1010, 1'b0, 1'b0, lat);
    check("after abort latency", lat, 8);
    check("after abort sum", sum0, 32'h1F1F_1F1F);

    // Randomized sweep across configurations
    for (int c = 0; c < 4; c++) begin
      for (int n = 0; n < 1000; n++) begin
        av = pick();
        bv = pick();
        s  = 1'($urandom_range(0, 1));
        ci = 1'($urandom_range(0, 1));
        run_op(c, av, bv, s, ci, lat);
        check($sformatf("cfg%0d op%0d latency", c, n), lat, ndig_c[c]);
        check($sformatf("cfg%0d op%0d result", c, n),
              {get_sum(c), cout_v[c], ovf_v[c]}, model(width_c[c], av, bv, s, ci));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised digit-serial two's-complement adder/subtractor for the datapath. It processes a WIDTH-bit operand pair DIGIT bits per clock, least-significant digit first, with the carry held in a register between digits. It replaces wide single-cycle carry chains where area matters more than latency. A start/busy/done handshake connects it to the control unit, and it reports carry-out and signed overflow.

## Interface
- WIDTH, 32: operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 4: bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when not busy.
- sub  in  1  0 = a+b+cin, 1 = a−b−cin (cin is a borrow-in).
- cin  in  1  carry/borrow in.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; result valid.
- sum  out  WIDTH  result; held until the next accepted start.
- cout  out  1  carry out of the MSB; with sub=1, 1 means no borrow.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- NDIG = WIDTH/DIGIT. States are IDLE and RUN; a digit counter runs 0..NDIG−1.
- Accept: in IDLE, start=1 does the following.
  - Latches a into an operand shift register.
  - Latches b XOR {WIDTH{sub}} into a second operand shift register.
  - Sets the carry register to cin XOR sub.
  - Clears the counter and enters RUN.
- RUN, each cycle:
  - The digit adder adds the low DIGIT bits of both shift registers plus the carry register.
  - The digit result shifts into sum from the MSB side, and both operand registers shift right by DIGIT.
  - The digit carry-out updates the carry register.
  - The counter increments.
- Last digit (counter = NDIG−1):
  - cout takes the final carry.
  - ovf takes the carry-into-MSB XOR the final carry.
  - done is set for one cycle and the state returns to IDLE.
- start while busy is ignored. start in the cycle where done=1 is accepted, since the state is already IDLE.
- Operand inputs are sampled only at accept. Changes during RUN have no effect.
- sum, cout and ovf update only on the final digit edge. Intermediate sum bits are not meaningful while busy=1.
- cin and sub apply to the whole operation. All arithmetic is modulo 2^WIDTH.

## Timing
- Reset drives every output to a known value: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0. The counter and carry register are also cleared.
- Reset mid-operation aborts the operation: no done pulse, and sum is cleared.
- Let edge E0 be the edge that accepts start:
  - busy=1 after E0.
  - Digit k is processed on edge E(k+1).
  - After E(NDIG): busy=0 and done=1.
  - After E(NDIG+1): done=0, unless a new start was accepted at E(NDIG+1), in which case busy=1 again.
- Latency is NDIG cycles from accept to done. Throughput is one operation per NDIG cycles when start is issued back-to-back.
- DIGIT=WIDTH gives NDIG=1: busy is high for one cycle and done follows on the next edge.
- busy and done are registered outputs with no combinational path from any input.

## Structure
- Shared package adder_pkg holds the following:
  - State encoding constants IDLE and RUN.
  - A function returning NDIG.
  - A function returning the counter width as max(1, clog2(NDIG)).
- Sub-module digit_adder is purely combinational, with parameter DIGIT:
  - Inputs: x[DIGIT], y[DIGIT], ci.
  - Outputs: s[DIGIT], co, c_msb, where c_msb is the carry into bit DIGIT−1.
  - It is a ripple of one-bit adder cells.
- serial_adder instantiates digit_adder once and owns the FSM, the counter, the shift registers and the flags.
- An elaboration-time check rejects configurations where WIDTH % DIGIT ≠ 0.

## Test plan
All scenarios use WIDTH=32 and DIGIT=4 unless stated.

- Wrap-around: a=0xFFFFFFFF, b=1, sub=0, cin=0 → done exactly 8 cycles after accept; sum=0x00000000, cout=1, ovf=0.
- Subtract with borrow: a=5, b=7, sub=1, cin=0 → sum=0xFFFFFFFE, cout=0, ovf=0. Repeat with cin=1 → sum=0xFFFFFFFD.
- Signed overflow: a=0x7FFFFFFF, b=1, sub=0 → sum=0x80000000, cout=0, ovf=1. Also a=0x80000000, b=1, sub=1 → sum=0x7FFFFFFF, ovf=1.
- Handshake:
  - Pulse start again 3 cycles into an operation with different operands → ignored; the original result is produced.
  - Assert start on the done cycle → accepted; busy=1 on the next cycle, and the second result arrives 8 cycles later.
- Reset mid-operation: assert rst at digit 4 → next cycle busy=0, done=0, sum=0. No done pulse follows, and a fresh start then completes normally.
- Configuration sweep, all against a reference model over 1000 random operands:
  - DIGIT=1: 32-cycle latency.
  - DIGIT=32: 1-cycle latency.
  - WIDTH=8, DIGIT=2: 4-cycle latency.
